// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: shared constants and types for the pixel fetch arbiter.
//   PIX_W          - framebuffer word width, {r[2:0],g[2:0],b[2:0]}
//   R_HI..B_LO     - colour field slice positions inside a pixel word
//   gnt_e          - which requester owns the RAM port this cycle
package pixel_fetch_pkg;

   localparam int PIX_W = 9;

   localparam int R_HI = 8;
   localparam int R_LO = 6;
   localparam int G_HI = 5;
   localparam int G_LO = 3;
   localparam int B_HI = 2;
   localparam int B_LO = 0;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_FETCH,
      GNT_HOST
   } gnt_e;

endpackage

// File: rtl/pixel_fetch_arb_fifo.sv
// pixel_fifo: synchronous FIFO used as the display prefetch buffer.
//   clk, reset   - clock, synchronous active-high reset
//   push, wdata  - write one entry (ignored when full and not popping)
//   pop, rdata   - rdata shows the head entry; pop advances it (ignored when empty)
//   flush        - empties the FIFO; wins over a same-cycle push
//   level        - number of valid entries, 0..DEPTH
//   empty, full  - level == 0 / level == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      level,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_level == '0);
   assign full  = (r_level == (AW+1)'(DEPTH));
   assign level = r_level;
   assign rdata = r_mem[r_rptr];

   assign w_do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/pixel_fetch_arb.sv
// pixel_fetch_arb: shares a single-port framebuffer RAM between the display
// prefetch path and a host write port, and feeds the dvid encoder one pixel
// per active cycle with sync/blank delayed to match.
//   clk, reset                  - pixel clock, synchronous active-high reset
//   hsync, vsync, blank         - from the timing generator
//   hsync_o, vsync_o, blank_o   - inputs delayed one cycle
//   red, green, blue            - pixel colour aligned with blank_o
//   wr_valid/addr/data, wr_ready- host write port; wr_ready is the same-cycle grant
//   mem_en/we/addr/wdata        - RAM access (at most one per cycle)
//   mem_rdata                   - RAM read data, one cycle after a read
//   underflow                   - sticky: an active pixel found the FIFO empty
// Optional macro PIXEL_FETCH_STATS_EN adds:
//   underflow_count             - saturating count of empty pops
//   host_wait                   - host requesting but not granted
module pixel_fetch_arb
   import pixel_fetch_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int FRAME_PIXELS = 19200,
   parameter int FIFO_DEPTH   = 8,
   parameter int LOW_WATER    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              blank,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              blank_o,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [2:0]        blue,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
`ifdef PIXEL_FETCH_STATS_EN
   output logic [15:0]       underflow_count,
   output logic              host_wait,
`endif
   output logic              underflow
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [LVL_W:0]    DEPTH_C = (LVL_W+1)'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  LOW_C   = LVL_W'(LOW_WATER);
   localparam logic [ADDR_W-1:0] FRAME_C = ADDR_W'(FRAME_PIXELS);

   logic              r_vsync;
   logic              r_hsync;
   logic              r_blank;
   logic [PIX_W-1:0]  r_pix;
   logic [ADDR_W-1:0] r_fetch_addr;
   logic              r_inflight;
   logic              r_underflow;

   logic              w_frame_start;
   logic [LVL_W-1:0]  w_level;
   logic [LVL_W:0]    w_credit;
   logic              w_empty;
   logic              w_full;
   logic [PIX_W-1:0]  w_head;
   logic              w_fetch_ok;
   gnt_e              w_gnt;

   assign w_frame_start = vsync & ~r_vsync;

   // Credit counts the read still on its way back, so the FIFO can never
   // be asked to take more than it has room for.
   assign w_credit   = {1'b0, w_level} + {{LVL_W{1'b0}}, r_inflight};
   assign w_fetch_ok = ~w_frame_start & ~w_full &
                       (w_credit < DEPTH_C) & (r_fetch_addr < FRAME_C);

   // Fetch normally yields to the host, but takes the port back whenever the
   // FIFO runs low so active video keeps flowing.
   always_comb begin
      w_gnt = GNT_NONE;
      if (!reset) begin
         if (w_fetch_ok && (w_level < LOW_C || !wr_valid)) w_gnt = GNT_FETCH;
         else if (wr_valid)                               w_gnt = GNT_HOST;
      end
   end

   assign mem_en    = (w_gnt != GNT_NONE);
   assign mem_we    = (w_gnt == GNT_HOST);
   assign wr_ready  = (w_gnt == GNT_HOST);
   assign mem_addr  = (w_gnt == GNT_HOST)  ? wr_addr :
                      (w_gnt == GNT_FETCH) ? r_fetch_addr : '0;
   assign mem_wdata = (w_gnt == GNT_HOST)  ? wr_data : '0;

   // A read that is still in flight when a frame starts lands in the same
   // cycle as the flush; flush wins, so the stale word is dropped.
   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (r_inflight),
      .pop   (~blank),
      .flush (w_frame_start),
      .wdata (mem_rdata),
      .rdata (w_head),
      .level (w_level),
      .empty (w_empty),
      .full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vsync      <= 1'b0;
         r_hsync      <= 1'b0;
         r_blank      <= 1'b0;
         r_pix        <= '0;
         r_fetch_addr <= '0;
         r_inflight   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_vsync    <= vsync;
         r_hsync    <= hsync;
         r_blank    <= blank;
         r_inflight <= (w_gnt == GNT_FETCH);

         if (w_frame_start)          r_fetch_addr <= '0;
         else if (w_gnt == GNT_FETCH) r_fetch_addr <= r_fetch_addr + ADDR_W'(1);

         r_pix <= (blank || w_empty) ? '0 : w_head;

         if (!blank && w_empty) r_underflow <= 1'b1;
      end
   end

   assign hsync_o   = r_hsync;
   assign vsync_o   = r_vsync;
   assign blank_o   = r_blank;
   assign red       = r_pix[R_HI:R_LO];
   assign green     = r_pix[G_HI:G_LO];
   assign blue      = r_pix[B_HI:B_LO];
   assign underflow = r_underflow;

`ifdef PIXEL_FETCH_STATS_EN
   logic [15:0] r_ucnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ucnt <= '0;
      end else if (!blank && w_empty && r_ucnt != 16'hFFFF) begin
         r_ucnt <= r_ucnt + 16'd1;
      end
   end

   assign underflow_count = r_ucnt;
   assign host_wait       = wr_valid & ~wr_ready;
`endif

endmodule
